// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - memory-mapped I/O responder: hex display, LEDs, buttons, optional timer
//
// Purpose:
//   Device end of the CPU io bus. Holds the SEG, LED and CTRL registers, scans an
//   8-digit multiplexed hex display, drives 16 LEDs, debounces 5 buttons into a
//   level register and a sticky press-event register. Reads are combinational,
//   writes commit on the rising clock edge.
//
// Optional feature macro:
//   IO_TIMER_EN - adds TCNT/TCMP/TSTAT tick timer with compare flag on irq_o.
//
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   io_ce_i     - bus access strobe
//   io_we_i     - 1 = write, 0 = read
//   io_addr_i   - byte address, bits [1:0] ignored
//   io_data_i   - write data
//   io_data_o   - combinational read data
//   seg_o       - segments {dp,g,f,e,d,c,b,a}, active-low
//   an_o        - digit selects, active-low
//   led_o       - LED drive
//   btn_i       - raw asynchronous buttons, active-high
//   irq_o       - timer match flag (0 without timer)

module mmio_periph #(
    parameter logic [15:0] SCAN_DIV   = 16'd50000,
    parameter logic [19:0] DEB_CYCLES = 20'd1000000,
    parameter logic [15:0] TICK_DIV   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ce_i,
    input  logic        io_we_i,
    input  logic [31:0] io_addr_i,
    input  logic [31:0] io_data_i,
    output logic [31:0] io_data_o,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic [15:0] led_o,
    input  logic [4:0]  btn_i,
    output logic        irq_o
);

    localparam logic [2:0] OFF_SEG   = 3'd0;
    localparam logic [2:0] OFF_LED   = 3'd1;
    localparam logic [2:0] OFF_CTRL  = 3'd2;
    localparam logic [2:0] OFF_BTN   = 3'd3;
    localparam logic [2:0] OFF_TCNT  = 3'd4;
    localparam logic [2:0] OFF_TCMP  = 3'd5;
    localparam logic [2:0] OFF_TSTAT = 3'd6;

    localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;
    localparam logic [19:0] DEB_LAST  = DEB_CYCLES - 20'd1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [2:0] offset;
    logic       wr_en;
    logic       rd_en;

    assign hit    = (io_addr_i[31:12] == 20'hFFFFF) && (io_addr_i[11:5] == 7'd0);
    assign offset = io_addr_i[4:2];
    assign wr_en  = io_ce_i & io_we_i & hit;
    assign rd_en  = io_ce_i & ~io_we_i & hit;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] seg_q,  seg_d;
    logic [15:0] led_q,  led_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] scan_pre_q, scan_pre_d;
    logic [2:0]  dig_idx_q,  dig_idx_d;
    logic [4:0]  sync1_q,  sync1_d;
    logic [4:0]  sync2_q,  sync2_d;
    logic [4:0]  stable_q, stable_d;
    logic [4:0]  evt_q,    evt_d;
    logic [19:0] deb_cnt_q [5];
    logic [19:0] deb_cnt_d [5];

    // ------------------------------------------------------------------
    // Register file writes
    // ------------------------------------------------------------------
    always_comb begin
        seg_d  = seg_q;
        led_d  = led_q;
        ctrl_d = ctrl_q;
        if (wr_en) begin
            case (offset)
                OFF_SEG:  seg_d  = io_data_i;
                OFF_LED:  led_d  = io_data_i[15:0];
                OFF_CTRL: ctrl_d = io_data_i[7:0];
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    always_comb begin
        scan_pre_d = scan_pre_q + 16'd1;
        dig_idx_d  = dig_idx_q;
        if (scan_pre_q == SCAN_LAST) begin
            scan_pre_d = 16'd0;
            dig_idx_d  = dig_idx_q + 3'd1;   // 7 wraps to 0 naturally
        end
    end

    logic [3:0] cur_nibble;
    logic [6:0] seg_pat;

    assign cur_nibble = seg_q[{dig_idx_q, 2'b00} +: 4];

    // Active-low gfedcba patterns for hex digits
    always_comb begin
        seg_pat = 7'h7F;
        case (cur_nibble)
            4'h0: seg_pat = 7'h40;
            4'h1: seg_pat = 7'h79;
            4'h2: seg_pat = 7'h24;
            4'h3: seg_pat = 7'h30;
            4'h4: seg_pat = 7'h19;
            4'h5: seg_pat = 7'h12;
            4'h6: seg_pat = 7'h02;
            4'h7: seg_pat = 7'h78;
            4'h8: seg_pat = 7'h00;
            4'h9: seg_pat = 7'h10;
            4'hA: seg_pat = 7'h08;
            4'hB: seg_pat = 7'h03;
            4'hC: seg_pat = 7'h46;
            4'hD: seg_pat = 7'h21;
            4'hE: seg_pat = 7'h06;
            4'hF: seg_pat = 7'h0E;
            default: seg_pat = 7'h7F;
        endcase
    end

    assign seg_o = {1'b1, seg_pat};
    assign an_o  = ctrl_q[dig_idx_q] ? ~(8'b1 << dig_idx_q) : 8'hFF;
    assign led_o = led_q;

    // ------------------------------------------------------------------
    // Button synchronizer, debounce and press events
    // ------------------------------------------------------------------
    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any return to agreement throws the partial count away,
    // which is what filters glitches shorter than DEB_CYCLES.
    always_comb begin
        sync1_d  = btn_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        evt_d    = evt_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
        end

        // Clear-on-read first so that a coincident press event overrides it
        if (rd_en && (offset == OFF_BTN)) begin
            evt_d = 5'd0;
        end

        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = 20'd0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = 20'd0;
                stable_d[i]  = sync2_q[i];
                if (sync2_q[i]) begin
                    evt_d[i] = 1'b1;
                end
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional tick timer
    // ------------------------------------------------------------------
`ifdef IO_TIMER_EN
    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

    logic [15:0] tpre_q,  tpre_d;
    logic [31:0] tcnt_q,  tcnt_d;
    logic [31:0] tcmp_q,  tcmp_d;
    logic        tstat_q, tstat_d;
    logic        tick;

    always_comb begin
        tpre_d  = tpre_q + 16'd1;
        tcnt_d  = tcnt_q;
        tcmp_d  = tcmp_q;
        tstat_d = tstat_q;
        tick    = 1'b0;

        if (tpre_q == TICK_LAST) begin
            tpre_d = 16'd0;
            tcnt_d = tcnt_q + 32'd1;
            tick   = 1'b1;
        end

        // A TCNT write takes priority over the increment and restarts the prescaler
        if (wr_en && (offset == OFF_TCNT)) begin
            tcnt_d = io_data_i;
            tpre_d = 16'd0;
            tick   = 1'b0;
        end
        if (wr_en && (offset == OFF_TCMP)) begin
            tcmp_d = io_data_i;
        end
        if (wr_en && (offset == OFF_TSTAT) && io_data_i[0]) begin
            tstat_d = 1'b0;
        end
        // Match set comes last so it beats a coincident clear
        if (tick && (tcnt_d == tcmp_q)) begin
            tstat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpre_q  <= 16'd0;
            tcnt_q  <= 32'd0;
            tcmp_q  <= 32'hFFFF_FFFF;
            tstat_q <= 1'b0;
        end else begin
            tpre_q  <= tpre_d;
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tstat_q <= tstat_d;
        end
    end

    assign irq_o = tstat_q;

    logic unused_bits;
    assign unused_bits = ^io_addr_i[1:0];
`else
    assign irq_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{io_addr_i[1:0], TICK_DIV};
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_data_o = 32'd0;
        if (hit) begin
            case (offset)
                OFF_SEG:   io_data_o = seg_q;
                OFF_LED:   io_data_o = {16'd0, led_q};
                OFF_CTRL:  io_data_o = {24'd0, ctrl_q};
                OFF_BTN:   io_data_o = {19'd0, evt_q, 3'd0, stable_q};
`ifdef IO_TIMER_EN
                OFF_TCNT:  io_data_o = tcnt_q;
                OFF_TCMP:  io_data_o = tcmp_q;
                OFF_TSTAT: io_data_o = {31'd0, tstat_q};
`endif
                default:   io_data_o = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= 32'd0;
            led_q      <= 16'd0;
            ctrl_q     <= 8'hFF;
            scan_pre_q <= 16'd0;
            dig_idx_q  <= 3'd0;
            sync1_q    <= 5'd0;
            sync2_q    <= 5'd0;
            stable_q   <= 5'd0;
            evt_q      <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= 20'd0;
            end
        end else begin
            seg_q      <= seg_d;
            led_q      <= led_d;
            ctrl_q     <= ctrl_d;
            scan_pre_q <= scan_pre_d;
            dig_idx_q  <= dig_idx_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            evt_q      <= evt_d;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - directed self-checking bench for mmio_periph

module tb_mmio_periph;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_ce = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_addr = 32'd0;
    logic [31:0] io_wdata = 32'd0;
    logic [31:0] io_rdata;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic [15:0] led;
    logic [4:0]  btn = 5'd0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_periph #(
        .SCAN_DIV   (16'd4),
        .DEB_CYCLES (20'd8),
        .TICK_DIV   (16'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_ce_i   (io_ce),
        .io_we_i   (io_we),
        .io_addr_i (io_addr),
        .io_data_i (io_wdata),
        .io_data_o (io_rdata),
        .seg_o     (seg),
        .an_o      (an),
        .led_o     (led),
        .btn_i     (btn),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; write commits on the next posedge, returns at the following negedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        io_ce = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
        @(negedge clk);
        io_ce = 1'b0; io_we = 1'b0;
    endtask

    // Called at a negedge; samples the combinational read, holds the access over one posedge
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        io_ce = 1'b1; io_we = 1'b0; io_addr = a;
        #1 d = io_rdata;
        @(negedge clk);
        io_ce = 1'b0;
    endtask

    logic [31:0] rd;
    logic [7:0]  prev_an;
    bit          found;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_an",  {24'd0, an},  32'h0000_00FE);
        check("rst_seg", {24'd0, seg}, 32'h0000_00C0);
        check("rst_led", {16'd0, led}, 32'h0000_0000);
        check("rst_irq", {31'd0, irq}, 32'h0000_0000);
        @(negedge clk);
        bus_read(32'hFFFF_F008, rd);
        check("rst_ctrl", rd, 32'h0000_00FF);
        bus_read(32'hFFFF_F00C, rd);
        check("rst_btn", rd, 32'h0000_0000);

        // ---------------- LED write / miss ----------------
        io_ce = 1'b1; io_we = 1'b1; io_addr = 32'hFFFF_F004; io_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("led_same_edge", {16'd0, led}, 32'h0000_BEEF);
        @(negedge clk);
        io_ce = 1'b0; io_we = 1'b0;
        bus_read(32'hFFFF_F004, rd);
        check("led_read", rd, 32'h0000_BEEF);
        bus_write(32'hFFFF_F020, 32'h1234_5678);
        bus_write(32'hFFFF_E004, 32'h0000_1111);
        check("miss_led", {16'd0, led}, 32'h0000_BEEF);
        bus_read(32'hFFFF_F020, rd);
        check("miss_read", rd, 32'h0000_0000);
        bus_read(32'hFFFF_F000, rd);
        check("miss_seg", rd, 32'h0000_0000);
        bus_read(32'hFFFF_F008, rd);
        check("miss_ctrl", rd, 32'h0000_00FF);

        // ---------------- display scan ----------------
        bus_write(32'hFFFF_F000, 32'h8765_432A);
        bus_write(32'hFFFF_F008, 32'h0000_0005);
        bus_read(32'hFFFF_F000, rd);
        check("seg_read", rd, 32'h8765_432A);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            prev_an = an;
            @(negedge clk);
            if (prev_an != 8'hFB && an == 8'hFB) found = 1'b1;
        end
        check("scan_found_d2", {31'd0, found}, 32'd1);
        check("d2_seg", {24'd0, seg}, 32'h0000_00B0);
        repeat (3) @(negedge clk);
        check("d2_hold_an", {24'd0, an}, 32'h0000_00FB);
        @(negedge clk);
        check("d3_an", {24'd0, an}, 32'h0000_00FF);
        repeat (20) @(negedge clk);
        check("d0_an",  {24'd0, an},  32'h0000_00FE);
        check("d0_seg", {24'd0, seg}, 32'h0000_0088);
        repeat (4) @(negedge clk);
        check("d1_an", {24'd0, an}, 32'h0000_00FF);

        // ---------------- buttons ----------------
        btn[2] = 1'b1;
        repeat (5) @(negedge clk);
        btn[2] = 1'b0;
        repeat (15) @(negedge clk);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_glitch", rd, 32'h0000_0000);

        btn[2] = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_held", rd, 32'h0000_0404);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_cleared", rd, 32'h0000_0004);
        btn[2] = 1'b0;
        repeat (15) @(negedge clk);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_release", rd, 32'h0000_0000);

        // Level rises on the 10th posedge after the press; read held over that edge
        btn[2] = 1'b1;
        repeat (9) @(negedge clk);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_before_accept", rd, 32'h0000_0000);
        bus_read(32'hFFFF_F00C, rd);
        check("btn_set_wins", rd, 32'h0000_0404);
        btn[2] = 1'b0;
        repeat (15) @(negedge clk);

        // ---------------- timer ----------------
`ifdef IO_TIMER_EN
        bus_read(32'hFFFF_F014, rd);
        check("tcmp_reset", rd, 32'hFFFF_FFFF);
        bus_write(32'hFFFF_F018, 32'h0000_0001);
        bus_write(32'hFFFF_F014, 32'h0000_0003);
        bus_write(32'hFFFF_F010, 32'h0000_0000);
        repeat (5) @(negedge clk);
        check("irq_before", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(32'hFFFF_F018, rd);
        check("tstat_set", rd, 32'h0000_0001);
        bus_write(32'hFFFF_F018, 32'h0000_0001);
        check("irq_clear", {31'd0, irq}, 32'd0);
        bus_write(32'hFFFF_F010, 32'hFFFF_FFFF);
        bus_read(32'hFFFF_F010, rd);
        check("tcnt_load", rd, 32'hFFFF_FFFF);
        bus_read(32'hFFFF_F010, rd);
        check("tcnt_hold", rd, 32'hFFFF_FFFF);
        bus_read(32'hFFFF_F010, rd);
        check("tcnt_wrap", rd, 32'h0000_0000);
`else
        bus_write(32'hFFFF_F010, 32'h0000_0055);
        bus_write(32'hFFFF_F014, 32'h0000_0000);
        bus_read(32'hFFFF_F010, rd);
        check("no_tcnt", rd, 32'h0000_0000);
        bus_read(32'hFFFF_F014, rd);
        check("no_tcmp", rd, 32'h0000_0000);
        repeat (10) @(negedge clk);
        check("no_irq", {31'd0, irq}, 32'd0);
`endif

        // ---------------- async reset mid-scan / mid-debounce ----------------
        btn[2] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_an",  {24'd0, an},  32'h0000_00FE);
        check("arst_seg", {24'd0, seg}, 32'h0000_00C0);
        check("arst_led", {16'd0, led}, 32'h0000_0000);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        bus_read(32'hFFFF_F008, rd);
        check("arst_ctrl", rd, 32'h0000_00FF);
        bus_read(32'hFFFF_F000, rd);
        check("arst_segreg", rd, 32'h0000_0000);
        btn[2] = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        bus_read(32'hFFFF_F00C, rd);
        check("arst_btn", rd, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
